// File: rtl/pixel_coord_gen.sv
// Row-major raster coordinate generator with valid/ready handshake and
// sof/eol/eof markers; frame dimensions are latched at each frame start.
//
// state | meaning
// IDLE  | no beat presented; waits for start
// RUN   | presenting (x, y) beats of the current frame
module pixel_coord_gen #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         continuous,
  input  logic [W-1:0] res_x,
  input  logic [W-1:0] res_y,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] res_y_out,
  output logic         valid,
  input  logic         ready,
  output logic         sof,
  output logic         eol,
  output logic         eof,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic         done_q, done_d;
  logic         last_x, last_y, accept, dims_ok;

  assign last_x  = (x_q == rx_q - W'(1));
  assign last_y  = (y_q == ry_q - W'(1));
  assign accept  = (state_q == RUN) && ready;
  assign dims_ok = (res_x != '0) && (res_y != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rx_d = res_x;
          ry_d = res_y;
          x_d  = '0;
          y_d  = '0;
          if (dims_ok) state_d = RUN;
          else         done_d  = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_x && last_y) begin
            x_d = '0;
            y_d = '0;
            // continuous mode re-latches the dimensions for a seamless restart
            if (continuous) begin
              rx_d = res_x;
              ry_d = res_y;
              if (!dims_ok) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else if (last_x) begin
            x_d = '0;
            y_d = y_q + W'(1);
          end else begin
            x_d = x_q + W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid     = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign x         = x_q;
  assign y         = y_q;
  assign res_y_out = ry_q;
  assign done      = done_q;
  assign sof       = valid && (x_q == '0) && (y_q == '0);
  assign eol       = valid && last_x;
  assign eof       = valid && last_x && last_y;

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Scoreboard bench for pixel_coord_gen: expected raster beats are queued when
// a frame is requested and popped on every accepted beat.
module tb_pixel_coord_gen;
  localparam int W = 11;

  logic         clk, rst_n, start, continuous, ready;
  logic [W-1:0] res_x, res_y;
  logic [W-1:0] x, y, res_y_out;
  logic         valid, sof, eol, eof, busy, done;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sof;
    logic         eol;
    logic         eof;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  pixel_coord_gen #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .res_x(res_x), .res_y(res_y), .x(x), .y(y), .res_y_out(res_y_out),
    .valid(valid), .ready(ready), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_raster(input int rx, input int ry);
    beat_t b;
    for (int yy = 0; yy < ry; yy++)
      for (int xx = 0; xx < rx; xx++) begin
        b.x   = W'(xx);
        b.y   = W'(yy);
        b.sof = (xx == 0) && (yy == 0);
        b.eol = (xx == rx - 1);
        b.eof = (xx == rx - 1) && (yy == ry - 1);
        sb.push_back(b);
      end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({valid, busy, done, sof, eol, eof, x, y, res_y_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b x=%0d y=%0d ry=%0d required all 0",
               valid, busy, done, x, y, res_y_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got valid=%b done=%b required 0 0", valid, done);
    end
  endtask

  task automatic test_basic();
    beat_t e;
    int beats = 0;
    logic pend_done = 1'b0, got_done = 1'b0;
    sb.delete();
    push_raster(4, 3);
    @(negedge clk);
    res_x = 4; res_y = 3; ready = 1'b1; continuous = 1'b0; start = 1'b1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) begin
        total++;
        if (valid !== 1'b1) begin
          bad++; $display("FAIL basic_first_valid: got %b required 1", valid);
        end
      end
      total++;
      if (done !== pend_done || (pend_done && valid !== 1'b0)) begin
        bad++; $display("FAIL basic_done: got done=%b valid=%b required done=%b valid=0", done, valid, pend_done);
      end
      got_done = pend_done;
      pend_done = 1'b0;
      if (valid && ready) begin
        beats++;
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL basic_extra_beat: got (%0d,%0d) required none", x, y);
        end else begin
          e = sb.pop_front();
          total++;
          if ({x, y, sof, eol, eof} !== e) begin
            bad++;
            $display("FAIL basic_beat%0d: got (%0d,%0d) s%b l%b f%b required (%0d,%0d) s%b l%b f%b",
                     beats, x, y, sof, eol, eof, e.x, e.y, e.sof, e.eol, e.eof);
          end
          total++;
          if (res_y_out !== W'(3)) begin
            bad++; $display("FAIL basic_res_y_out: got %0d required 3", res_y_out);
          end
          pend_done = e.eof;
        end
      end
    end
    total++;
    if (!got_done || beats != 12) begin
      bad++; $display("FAIL basic_frame: got beats=%0d done_seen=%b required 12 1", beats, got_done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL basic_done_width: got done=%b valid=%b required 0 0", done, valid);
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    int beats = 0;
    logic pend_done = 1'b0, got_done = 1'b0, stalled = 1'b0;
    logic [3*W+3-1:0] held = '0;
    sb.delete();
    push_raster(3, 2);
    @(negedge clk);
    res_x = 3; res_y = 2; continuous = 1'b0; ready = 1'b0; start = 1'b1;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (stalled) begin
        total++;
        if ({x, y, res_y_out, sof, eol, eof} !== held) begin
          bad++; $display("FAIL bp_hold: got %h required %h", {x, y, res_y_out, sof, eol, eof}, held);
        end
      end
      total++;
      if (done !== pend_done) begin
        bad++; $display("FAIL bp_done: got %b required %b", done, pend_done);
      end
      got_done = pend_done;
      pend_done = 1'b0;
      ready = (c < 2) ? 1'b0 : 1'(($urandom_range(0, 2) != 0));
      stalled = valid && !ready;
      held = {x, y, res_y_out, sof, eol, eof};
      if (valid && ready) begin
        beats++;
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL bp_extra_beat: got (%0d,%0d) required none", x, y);
        end else begin
          e = sb.pop_front();
          total++;
          if ({x, y, sof, eol, eof} !== e || res_y_out !== W'(2)) begin
            bad++;
            $display("FAIL bp_beat%0d: got (%0d,%0d) s%b l%b f%b ry=%0d required (%0d,%0d) s%b l%b f%b ry=2",
                     beats, x, y, sof, eol, eof, res_y_out, e.x, e.y, e.sof, e.eol, e.eof);
          end
          pend_done = e.eof;
        end
      end
    end
    total++;
    if (!got_done || beats != 6) begin
      bad++; $display("FAIL bp_frame: got beats=%0d done_seen=%b required 6 1", beats, got_done);
    end
    ready = 1'b1;
  endtask

  task automatic test_zero_dim();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      res_x = (k == 0) ? W'(0) : W'(5);
      res_y = (k == 0) ? W'(5) : W'(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL zero_dim%0d_pulse: got done=%b valid=%b busy=%b required 1 0 0", k, done, valid, busy);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total++;
        if (done !== 1'b0 || valid !== 1'b0) begin
          bad++; $display("FAIL zero_dim%0d_after: got done=%b valid=%b required 0 0", k, done, valid);
        end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    beat_t e;
    int beats = 0;
    logic pend_done = 1'b0, got_done = 1'b0;
    sb.delete();
    push_raster(2, 2);
    @(negedge clk);
    res_x = 2; res_y = 2; ready = 1'b1; continuous = 1'b0; start = 1'b1;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      start = (c == 1);
      if (c == 1) res_x = 7;
      total++;
      if (done !== pend_done) begin
        bad++; $display("FAIL ign_done: got %b required %b", done, pend_done);
      end
      got_done = pend_done;
      pend_done = 1'b0;
      if (valid && ready) begin
        beats++;
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL ign_extra_beat: got (%0d,%0d) required none", x, y);
        end else begin
          e = sb.pop_front();
          total++;
          if ({x, y, sof, eol, eof} !== e) begin
            bad++;
            $display("FAIL ign_beat%0d: got (%0d,%0d) s%b l%b f%b required (%0d,%0d) s%b l%b f%b",
                     beats, x, y, sof, eol, eof, e.x, e.y, e.sof, e.eol, e.eof);
          end
          pend_done = e.eof;
        end
      end
    end
    total++;
    if (!got_done || beats != 4) begin
      bad++; $display("FAIL ign_frame: got beats=%0d done_seen=%b required 4 1", beats, got_done);
    end
  endtask

  task automatic test_continuous();
    beat_t e;
    int beats = 0;
    logic pend_done = 1'b0, got_done = 1'b0;
    sb.delete();
    push_raster(2, 1);
    push_raster(2, 1);
    push_raster(2, 1);
    @(negedge clk);
    res_x = 2; res_y = 1; ready = 1'b1; continuous = 1'b1; start = 1'b1;
    for (int c = 0; c < 30 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (done !== pend_done) begin
        bad++; $display("FAIL cont_done: got %b required %b", done, pend_done);
      end
      got_done = pend_done;
      pend_done = 1'b0;
      if (beats < 6 && !valid) begin
        total++; bad++; $display("FAIL cont_gap: got valid=0 after %0d beats required 1", beats);
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL cont_extra_beat: got (%0d,%0d) required none", x, y);
        end else begin
          e = sb.pop_front();
          total++;
          if ({x, y, sof, eol, eof} !== e) begin
            bad++;
            $display("FAIL cont_beat%0d: got (%0d,%0d) s%b l%b f%b required (%0d,%0d) s%b l%b f%b",
                     beats, x, y, sof, eol, eof, e.x, e.y, e.sof, e.eol, e.eof);
          end
          pend_done = e.eof && !continuous;
        end
        beats++;
        if (beats == 5) continuous = 1'b0;
      end
    end
    total++;
    if (!got_done || beats != 6) begin
      bad++; $display("FAIL cont_frames: got beats=%0d done_seen=%b required 6 1", beats, got_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    beat_t e;
    int beats = 0;
    logic pend_done = 1'b0, got_done = 1'b0;
    @(negedge clk);
    res_x = 4; res_y = 3; ready = 1'b1; continuous = 1'b0; start = 1'b1;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid && ready) beats++;
    end
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || x !== W'(0) || y !== W'(1)) begin
      bad++; $display("FAIL rst_beat5: got valid=%b (%0d,%0d) required 1 (0,1)", valid, x, y);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({valid, busy, done, sof, eol, eof, x, y, res_y_out} !== '0) begin
      bad++;
      $display("FAIL rst_async: got v=%b b=%b d=%b x=%0d y=%0d ry=%0d required all 0",
               valid, busy, done, x, y, res_y_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL rst_idle: got valid=%b done=%b required 0 0", valid, done);
      end
    end
    sb.delete();
    push_raster(4, 3);
    beats = 0;
    start = 1'b1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (done !== pend_done) begin
        bad++; $display("FAIL rst_restart_done: got %b required %b", done, pend_done);
      end
      got_done = pend_done;
      pend_done = 1'b0;
      if (valid && ready) begin
        beats++;
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL rst_extra_beat: got (%0d,%0d) required none", x, y);
        end else begin
          e = sb.pop_front();
          total++;
          if ({x, y, sof, eol, eof} !== e) begin
            bad++;
            $display("FAIL rst_restart_beat%0d: got (%0d,%0d) s%b l%b f%b required (%0d,%0d) s%b l%b f%b",
                     beats, x, y, sof, eol, eof, e.x, e.y, e.sof, e.eol, e.eof);
          end
          pend_done = e.eof;
        end
      end
    end
    total++;
    if (!got_done || beats != 12) begin
      bad++; $display("FAIL rst_restart_frame: got beats=%0d done_seen=%b required 12 1", beats, got_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ready = 1'b0;
    res_x = '0; res_y = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_ignored_inputs();
    test_continuous();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_coord_gen.md
# pixel_coord_gen

Generates the raster sequence of screen-space pixel coordinates (x, y) that feeds the screen-to-world conversion stage, one coordinate pair per accepted beat. It steps row-major over a frame of res_x × res_y pixels, latched at frame start, and presents each pair on a valid/ready handshake with start-of-frame, end-of-line and end-of-frame markers. It sits between the frame controller, which issues `start`, and the coordinate converter / shading pipeline, which drives `ready`.

## Interface
- `W`, default 11: coordinate and resolution width in bits; must hold values up to 1280.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request, sampled only in IDLE.
- `continuous`  in  1  if high when the last pixel is accepted, the next frame starts with no idle gap.
- `res_x`  in  W  frame width, latched at frame start.
- `res_y`  in  W  frame height, latched at frame start.
- `x`  out  W  current pixel column.
- `y`  out  W  current pixel row.
- `res_y_out`  out  W  latched height, passed with each beat for the downstream converter.
- `valid`  out  1  x/y/markers hold a beat.
- `ready`  in  1  downstream accepts the beat.
- `sof`  out  1  beat is (0,0).
- `eol`  out  1  beat has x == res_x-1.
- `eof`  out  1  beat is the last pixel (res_x-1, res_y-1).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last pixel of a non-continuous frame is accepted.

## Operation
- States: IDLE and RUN.
- IDLE:
  - `valid`=0 and `busy`=0.
  - `start`=1 latches res_x/res_y, then:
    - both nonzero: load x=0, y=0 and go to RUN.
    - either zero: stay in IDLE, pulse `done` next cycle, never assert `valid`.
- RUN:
  - `valid`=1 continuously.
  - A beat is accepted when `valid && ready`. Only then do x/y advance.
  - Advance rule: x+1. If x == res_x-1, x wraps to 0 and y increments.
- Last pixel accepted:
  - `continuous`=1: re-latch res_x/res_y. If both are nonzero, restart at (0,0) in RUN, with `valid` staying high and the next beat carrying `sof`. If either is zero, go to IDLE and pulse `done`.
  - `continuous`=0: go to IDLE and pulse `done` in the following cycle.
- `start` is ignored in RUN.
- res_x/res_y changes mid-frame are ignored. Only the latched values are used.
- Markers are combinational from the registered x/y and latched resolution:
  - `sof` = (x==0 && y==0).
  - `eol` = (x==res_x_l-1).
  - `eof` = `eol` && (y==res_y_l-1).
  - All markers are gated by `valid`.
- `res_y_out` = latched res_y; stable for the whole frame.
- Counter width is W. Comparisons use the latched values, so no overflow occurs for any res up to 2^W-1.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, x=0, y=0, res latches=0, `valid`=0, `busy`=0, `done`=0; all markers 0.
- `start` sampled high at edge n: `valid`=1 with (0,0) and `sof`=1 from edge n onward, i.e. visible in cycle n+1.
- Throughput: one beat per cycle while `ready`=1. A W×H frame occupies W·H cycles of `valid`.
- Backpressure: while `valid && !ready`, x, y, markers and `res_y_out` hold exactly.
- `done` goes high in the cycle after the edge that accepts the `eof` beat, for exactly one cycle; `valid`=0 in that cycle.
- Continuous restart: the beat after `eof` is (0,0) on the very next cycle. There is no bubble and no `done`.
- Asserting `rst_n` low mid-frame returns all outputs to reset values immediately. After release, nothing happens until a new `start`.

## Test plan
- res 4×3, `ready`=1, `start` pulse:
  - 12 beats in scan order (0,0),(1,0)…(3,2).
  - `sof` on beat 1 only; `eol` on beats 4, 8, 12; `eof` on beat 12 only.
  - `done` one cycle after beat 12; `res_y_out`=3 throughout.
- Backpressure, res 3×2, `ready` toggled in a pseudo-random pattern: the accepted sequence equals the 6-beat raster exactly, and outputs are stable while `ready`=0.
- Zero dimension, res_x=0, res_y=5, `start`: `valid` never rises and `done` pulses one cycle later. Repeat with res 5×0: same response.
- Ignored inputs, res 2×2: a `start` pulse and a change of res_x to 7 during RUN leave the frame at exactly 4 beats.
- Continuous mode, res 2×1, `continuous`=1:
  - Frames back to back: (0,0),(1,0),(0,0),… with no gap.
  - Drop `continuous` before the last beat: `done` after that frame.
- Reset mid-frame: drop `rst_n` at beat 5 of a 4×3 frame. All outputs are 0 asynchronously. After release and a new `start`, the frame restarts from (0,0).
